// File: rtl/decoder_3to8.sv
// Binary-to-one-hot select decoder with selectable active level and an optional
// output register (1-cycle latency, asynchronous active-low reset).
module decoder_3to8 #(
    parameter int unsigned N          = 3,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter bit          REGISTERED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         A,
    output logic [(1<<N)-1:0]    B,
    output logic                 valid
);

    localparam int unsigned W = 1 << N;
    localparam logic [W-1:0] INACTIVE = {W{ACTIVE_LOW}};

    logic [W-1:0] onehot_c;
    logic         valid_c;
    logic [W-1:0] b_d;

    // Full compare against every line so no latch and never multi-hot for known A
    always_comb begin
        onehot_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            onehot_c[i] = en && (A == N'(i));
        end
    end

    assign valid_c = |onehot_c;
    assign b_d     = ACTIVE_LOW ? ~onehot_c : onehot_c;

    generate
        if (REGISTERED) begin : g_reg
            logic [W-1:0] b_q;
            logic         valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q     <= INACTIVE;
                    valid_q <= 1'b0;
                end else begin
                    b_q     <= b_d;
                    valid_q <= valid_c;
                end
            end

            assign B     = b_q;
            assign valid = valid_q;
        end else begin : g_comb
            assign B     = b_d;
            assign valid = valid_c;
        end
    endgenerate

    // At most one decoded line whenever the select inputs are known
    always_comb begin
        if (!$isunknown({en, A})) begin
            assert ($onehot0(onehot_c))
                else $error("decoder_3to8: multi-hot decode");
        end
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: vector table, reset/enable/wrap
// sequences, and random stimulus against a behavioural reference.
module tb_decoder_3to8;

    typedef struct {
        logic       en;
        logic [2:0] a;
        logic [7:0] b;
        logic       v;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] a;
    logic [7:0] b_hi, b_lo, b_c;
    logic       v_hi, v_lo, v_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_3to8 dut (
        .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b_hi), .valid(v_hi)
    );

    decoder_3to8 #(.N(3), .ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b_lo), .valid(v_lo)
    );

    decoder_3to8 #(.N(3), .ACTIVE_LOW(1'b1), .REGISTERED(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b_c), .valid(v_c)
    );

    function automatic logic [7:0] ref_dec(input logic e, input int unsigned sel);
        int unsigned val;
        val = e ? 2 ** sel : 0;
        return 8'(val);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        logic       pen;
        logic [2:0] pa;

        vecs[0]  = '{1'b1, 3'd0, 8'h01, 1'b1};
        vecs[1]  = '{1'b1, 3'd1, 8'h02, 1'b1};
        vecs[2]  = '{1'b1, 3'd2, 8'h04, 1'b1};
        vecs[3]  = '{1'b1, 3'd3, 8'h08, 1'b1};
        vecs[4]  = '{1'b1, 3'd4, 8'h10, 1'b1};
        vecs[5]  = '{1'b1, 3'd5, 8'h20, 1'b1};
        vecs[6]  = '{1'b1, 3'd6, 8'h40, 1'b1};
        vecs[7]  = '{1'b1, 3'd7, 8'h80, 1'b1};
        vecs[8]  = '{1'b1, 3'd0, 8'h01, 1'b1};
        vecs[9]  = '{1'b0, 3'd3, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 3'd3, 8'h08, 1'b1};
        vecs[11] = '{1'b1, 3'd7, 8'h80, 1'b1};

        // Asynchronous reset before any clock edge
        rst_n = 1'b1;
        en    = 1'b1;
        a     = 3'd5;
        #1 rst_n = 1'b0;
        #1;
        check("reset_b",        b_hi,       8'h00);
        check("reset_valid",    {7'd0, v_hi}, 8'h00);
        check("reset_b_al",     b_lo,       8'hFF);
        check("reset_valid_al", {7'd0, v_lo}, 8'h00);

        tick();
        check("reset_hold_b", b_hi, 8'h00);
        rst_n = 1'b1;
        tick();
        check("first_decode_b",     b_hi,         8'h20);
        check("first_decode_valid", {7'd0, v_hi}, 8'h01);

        // Table: apply, clock once, expect decode one cycle later
        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en;
            a  = vecs[i].a;
            tick();
            check($sformatf("vec%0d_b", i),     b_hi,         vecs[i].b);
            check($sformatf("vec%0d_valid", i), {7'd0, v_hi}, {7'd0, vecs[i].v});
            check($sformatf("vec%0d_b_al", i),  b_lo,         ~vecs[i].b);
        end

        // Wrap 7 -> 0 on consecutive cycles, also sampled mid-cycle
        en = 1'b1;
        a  = 3'd0;
        @(negedge clk);
        check("wrap_hold_mid", b_hi, 8'h80);
        @(posedge clk);
        #1;
        check("wrap_to_zero", b_hi, 8'h01);

        // Mid-operation reset between edges
        a = 3'd6;
        tick();
        check("midrst_pre", b_hi, 8'h40);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_b_now",     b_hi,         8'h00);
        check("midrst_valid_now", {7'd0, v_hi}, 8'h00);
        check("midrst_b_al_now",  b_lo,         8'hFF);
        tick();
        check("midrst_held", b_hi, 8'h00);
        rst_n = 1'b1;
        #1;
        check("midrst_release_noedge", b_hi, 8'h00);
        tick();
        check("midrst_first_edge", b_hi, 8'h40);

        // Combinational active-low instance: zero latency
        en = 1'b1;
        a  = 3'd2;
        #1;
        check("comb_al_b",     b_c,         8'hFB);
        check("comb_al_valid", {7'd0, v_c}, 8'h01);
        en = 1'b0;
        #1;
        check("comb_al_dis_b",     b_c,         8'hFF);
        check("comb_al_dis_valid", {7'd0, v_c}, 8'h00);

        // Random stimulus against the reference model
        tick();
        pen = en;
        pa  = a;
        for (int k = 0; k < 300; k++) begin
            en = ($urandom % 4) != 0;
            a  = 3'($urandom % 8);
            #1;
            check("rand_comb_b",     b_c,         ~ref_dec(en, a));
            check("rand_comb_valid", {7'd0, v_c}, {7'd0, en});
            pen = en;
            pa  = a;
            tick();
            check("rand_reg_b",     b_hi,         ref_dec(pen, pa));
            check("rand_reg_valid", {7'd0, v_hi}, {7'd0, pen});
            check("rand_reg_b_al",  b_lo,         ~ref_dec(pen, pa));
            check("rand_onehot",    8'($countones(b_hi)), {7'd0, pen});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
